// File: rtl/counter_arbiter.sv
// Two-requester round-robin front end for a 16-bit up/down counter.
// Each granted transaction issues load/step strobes, then acks its owner.
module counter_arbiter (
   input  logic        CLK,
   input  logic        clear,
   input  logic        req0,
   input  logic        req1,
   input  logic [1:0]  op0,
   input  logic [1:0]  op1,
   input  logic [15:0] arg0,
   input  logic [15:0] arg1,
   output logic        ack0,
   output logic        ack1,
   output logic        err0,
   output logic        err1,
   output logic        ctr_up,
   output logic        ctr_down,
   output logic        ctr_load,
   output logic [15:0] ctr_data,
   input  logic        ctr_oFlow,
   output logic        busy,
   output logic        gnt
);

   localparam int unsigned W = 16;
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t         state;
   logic           last_q;
   logic           err_acc;
   logic           step_q;
   logic [W-1:0]   rem;

   logic           sel_c;
   logic [1:0]     op_c;
   logic [W-1:0]   arg_c;
   logic           err_c;

   // Round-robin pick: on a tie the requester not granted last wins.
   always_comb begin
      sel_c = req1;
      if (req0 && req1) begin
         sel_c = ~last_q;
      end
      op_c  = sel_c ? op1  : op0;
      arg_c = sel_c ? arg1 : arg0;
   end

   // The last step's overflow only shows up during DONE, so it is folded in here.
   assign err_c = err_acc | (ctr_oFlow & step_q);
   assign err0  = ack0 & err_c;
   assign err1  = ack1 & err_c;

   always_ff @(posedge CLK or negedge clear) begin
      if (!clear) begin
         state    <= IDLE;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         ctr_up   <= 1'b0;
         ctr_down <= 1'b0;
         ctr_load <= 1'b0;
         ctr_data <= '0;
         busy     <= 1'b0;
         gnt      <= 1'b0;
         last_q   <= 1'b1;
         err_acc  <= 1'b0;
         step_q   <= 1'b0;
         rem      <= '0;
      end else begin
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         step_q <= ctr_up | ctr_down;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  state   <= EXEC;
                  busy    <= 1'b1;
                  gnt     <= sel_c;
                  err_acc <= (op_c == OP_RSVD);
                  rem     <= '0;
                  case (op_c)
                     OP_LOAD: begin
                        ctr_load <= 1'b1;
                        ctr_data <= arg_c;
                     end
                     OP_UP: begin
                        if (arg_c != '0) begin
                           ctr_up <= 1'b1;
                           rem    <= arg_c - W'(1);
                        end
                     end
                     OP_DOWN: begin
                        if (arg_c != '0) begin
                           ctr_down <= 1'b1;
                           rem      <= arg_c - W'(1);
                        end
                     end
                     default: ;
                  endcase
               end
            end
            EXEC: begin
               if (ctr_oFlow && step_q) begin
                  err_acc <= 1'b1;
               end
               if (rem != '0) begin
                  rem <= rem - W'(1);
               end else begin
                  state    <= DONE;
                  ctr_up   <= 1'b0;
                  ctr_down <= 1'b0;
                  ctr_load <= 1'b0;
                  ctr_data <= '0;
                  ack0     <= ~gnt;
                  ack1     <= gnt;
               end
            end
            DONE: begin
               if (ctr_oFlow && step_q) begin
                  err_acc <= 1'b1;
               end
               state  <= IDLE;
               busy   <= 1'b0;
               last_q <= gnt;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
